// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated junction phase scheduler. Main road rests green and yields
// only to latched turn/side/pedestrian demand; emergency forces all-red.
module traffic_phase_scheduler #(
  parameter int T_MIN_MAIN = 7,
  parameter int T_TURN     = 5,
  parameter int T_SIDE     = 3,
  parameter int T_YEL      = 2,
  parameter int T_ALLRED   = 1,
  parameter int CW         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_turn,
  input  logic       req_side,
  input  logic       req_ped,
  input  logic       emerg,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       ped_walk,
  output logic [2:0] pend,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MG = 3'd0, MY = 3'd1, TG = 3'd2, TY = 3'd3,
    SG = 3'd4, SY = 3'd5, AR = 3'd6, EM = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  localparam logic [CW-1:0] L_MIN  = CW'(T_MIN_MAIN - 1);
  localparam logic [CW-1:0] L_TURN = CW'(T_TURN - 1);
  localparam logic [CW-1:0] L_SIDE = CW'(T_SIDE - 1);
  localparam logic [CW-1:0] L_YEL  = CW'(T_YEL - 1);
  localparam logic [CW-1:0] L_AR   = CW'(T_ALLRED - 1);

  state_t          r_state, w_state_nxt;
  state_t          r_nxt, w_nxt_nxt;
  logic [CW-1:0]   r_timer, w_timer_nxt;
  logic [2:0]      r_pend, w_pend_nxt;
  logic            r_walk_en, w_walk_en_nxt;
  logic [2:0]      w_set, w_clr;
  logic            w_tg_entry, w_sg_entry, w_changing;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= AR;
      r_nxt     <= MG;
      r_timer   <= '0;
      r_pend    <= 3'b000;
      r_walk_en <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_nxt     <= w_nxt_nxt;
      r_timer   <= w_timer_nxt;
      r_pend    <= w_pend_nxt;
      r_walk_en <= w_walk_en_nxt;
    end
  end

  // Phase transitions; only evaluated on tick cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_nxt_nxt   = r_nxt;
    if (tick) begin
      case (r_state)
        MG: if (emerg || ((r_timer == L_MIN) && (|r_pend))) w_state_nxt = MY;
        MY: if (r_timer == L_YEL) begin
              w_state_nxt = AR;
              w_nxt_nxt   = r_pend[0] ? TG : SG;
            end
        TG: if (emerg || (r_timer == L_TURN)) w_state_nxt = TY;
        TY: if (r_timer == L_YEL) begin
              w_state_nxt = AR;
              w_nxt_nxt   = (r_pend[1] | r_pend[2]) ? SG : MG;
            end
        SG: if (emerg || (r_timer == L_SIDE)) w_state_nxt = SY;
        SY: if (r_timer == L_YEL) begin
              w_state_nxt = AR;
              w_nxt_nxt   = MG;
            end
        AR: if (r_timer == L_AR) w_state_nxt = emerg ? EM : r_nxt;
        EM: if (!emerg) begin
              w_state_nxt = AR;
              w_nxt_nxt   = MG;
            end
        default: w_state_nxt = AR;
      endcase
    end
  end

  // MG saturates at its minimum so demand can be served on any later tick.
  always_comb begin
    w_changing  = (w_state_nxt != r_state);
    w_timer_nxt = r_timer;
    if (w_changing) begin
      w_timer_nxt = '0;
    end else if (tick && (r_state != EM)) begin
      if (!((r_state == MG) && (r_timer == L_MIN))) w_timer_nxt = r_timer + 1'b1;
    end
  end

  // Demand latches: the serving green masks its own inputs and clear wins.
  always_comb begin
    w_tg_entry    = (w_state_nxt == TG) && (r_state != TG);
    w_sg_entry    = (w_state_nxt == SG) && (r_state != SG);
    w_set         = {req_ped  & (r_state != SG),
                     req_side & (r_state != SG),
                     req_turn & (r_state != TG)};
    w_clr         = {w_sg_entry, w_sg_entry, w_tg_entry};
    w_pend_nxt    = (r_pend | w_set) & ~w_clr;
    w_walk_en_nxt = r_walk_en;
    if (w_sg_entry) begin
      w_walk_en_nxt = r_pend[2];
    end else if ((r_state == SG) && (w_state_nxt != SG)) begin
      w_walk_en_nxt = 1'b0;
    end
  end

  always_comb begin
    light_M1 = LAMP_R;
    light_M2 = LAMP_R;
    light_MT = LAMP_R;
    light_S  = LAMP_R;
    case (r_state)
      MG: begin light_M1 = LAMP_G; light_M2 = LAMP_G; end
      MY: begin light_M1 = LAMP_Y; light_M2 = LAMP_Y; end
      TG: light_MT = LAMP_G;
      TY: light_MT = LAMP_Y;
      SG: light_S  = LAMP_G;
      SY: light_S  = LAMP_Y;
      default: ;
    endcase
  end

  assign ped_walk = (r_state == SG) && r_walk_en;
  assign pend     = r_pend;
  assign phase    = r_state;

endmodule
